// File: rtl/barrido_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller: the active-high
// hex font (bit0 = a ... bit6 = g) and a width helper that is safe for tiny counts.
package barrido_pkg;

   localparam logic [6:0] FONT_0 = 7'h3F;
   localparam logic [6:0] FONT_1 = 7'h06;
   localparam logic [6:0] FONT_2 = 7'h5B;
   localparam logic [6:0] FONT_3 = 7'h4F;
   localparam logic [6:0] FONT_4 = 7'h66;
   localparam logic [6:0] FONT_5 = 7'h6D;
   localparam logic [6:0] FONT_6 = 7'h7D;
   localparam logic [6:0] FONT_7 = 7'h07;
   localparam logic [6:0] FONT_8 = 7'h7F;
   localparam logic [6:0] FONT_9 = 7'h6F;
   localparam logic [6:0] FONT_A = 7'h77;
   localparam logic [6:0] FONT_B = 7'h7C;
   localparam logic [6:0] FONT_C = 7'h39;
   localparam logic [6:0] FONT_D = 7'h5E;
   localparam logic [6:0] FONT_E = 7'h79;
   localparam logic [6:0] FONT_F = 7'h71;

   localparam logic [6:0] SEG_APAGADO = 7'h00;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int ancho_seguro(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module decodificador_7seg
   import barrido_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segmentos
);

   always_comb begin
      unique case (nibble)
         4'h0:    segmentos = FONT_0;
         4'h1:    segmentos = FONT_1;
         4'h2:    segmentos = FONT_2;
         4'h3:    segmentos = FONT_3;
         4'h4:    segmentos = FONT_4;
         4'h5:    segmentos = FONT_5;
         4'h6:    segmentos = FONT_6;
         4'h7:    segmentos = FONT_7;
         4'h8:    segmentos = FONT_8;
         4'h9:    segmentos = FONT_9;
         4'hA:    segmentos = FONT_A;
         4'hB:    segmentos = FONT_B;
         4'hC:    segmentos = FONT_C;
         4'hD:    segmentos = FONT_D;
         4'hE:    segmentos = FONT_E;
         default: segmentos = FONT_F;
      endcase
   end

endmodule

// File: rtl/barrido_displays_param.sv
// Multiplexed 7-segment scan controller: refresh prescaler, frame-coherent capture,
// anti-ghosting guard, leading-zero suppression, per-digit mask and frame tick.
module barrido_displays_param
   import barrido_pkg::*;
#(
   parameter int N_DIGITOS         = 8,
   parameter int DIV_REFRESCO      = 100000,
   parameter int GUARDA            = 64,
   parameter bit ANODO_ACTIVO_BAJO = 1'b1,
   parameter bit SEG_ACTIVO_BAJO   = 1'b1
) (
   input  logic                                 reloj,
   input  logic                                 reset,
   input  logic                                 habilitar,
   input  logic [4*N_DIGITOS-1:0]               digitos,
   input  logic [N_DIGITOS-1:0]                 puntos,
   input  logic [N_DIGITOS-1:0]                 mascara,
   input  logic                                 supresion_ceros,
   output logic [ancho_seguro(N_DIGITOS)-1:0]   indice,
   output logic [N_DIGITOS-1:0]                 anodos,
   output logic [6:0]                           segmentos,
   output logic                                 punto,
   output logic                                 tick_cuadro
);

   localparam int AI = ancho_seguro(N_DIGITOS);
   localparam int AP = ancho_seguro(DIV_REFRESCO);

   localparam logic [AP-1:0]        PRE_MAX    = AP'(DIV_REFRESCO - 1);
   localparam logic [AP-1:0]        PRE_GUARDA = AP'(GUARDA);
   localparam logic [AI-1:0]        IDX_MAX    = AI'(N_DIGITOS - 1);
   localparam logic [N_DIGITOS-1:0] ANODOS_OFF = ANODO_ACTIVO_BAJO ? '1 : '0;
   localparam logic [6:0]           SEG_OFF    = SEG_ACTIVO_BAJO ? ~SEG_APAGADO : SEG_APAGADO;
   localparam logic                 PUNTO_OFF  = SEG_ACTIVO_BAJO;

   logic [AP-1:0]          pre;
   logic [4*N_DIGITOS-1:0] sombra_dig;
   logic [N_DIGITOS-1:0]   sombra_pts;
   logic [N_DIGITOS-1:0]   sombra_msk;
   logic                   sombra_sup;

   logic                   fin_slot;
   logic                   fin_cuadro;
   logic                   captura;
   logic [N_DIGITOS-1:0]   ceros_arriba;
   logic [3:0]             nibble_sel;
   logic [6:0]             seg_dec;
   logic                   blanco;
   logic                   en_guarda;
   logic [N_DIGITOS-1:0]   an_act;
   logic [6:0]             seg_act;
   logic                   pt_act;

   assign fin_slot   = (pre == PRE_MAX);
   assign fin_cuadro = fin_slot && (indice == IDX_MAX);
   assign captura    = habilitar && (pre == '0) && (indice == '0);

   // Prescaler, slot index and frame shadow registers.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge reloj) begin
      if (reset) begin
         pre         <= '0;
         indice      <= '0;
         tick_cuadro <= 1'b0;
         // NOTE: shadow registers are reset so the first frame shows known content.
         sombra_dig  <= '0;
         sombra_pts  <= '0;
         sombra_msk  <= '0;
         sombra_sup  <= 1'b0;
      end else begin
         tick_cuadro <= habilitar && fin_cuadro;
         if (habilitar) begin
            pre <= fin_slot ? '0 : pre + 1'b1;
            if (fin_slot) begin
               indice <= (indice == IDX_MAX) ? '0 : indice + 1'b1;
            end
            if (captura) begin
               sombra_dig <= digitos;
               sombra_pts <= puntos;
               sombra_msk <= mascara;
               sombra_sup <= supresion_ceros;
            end
         end
      end
   end

   // ceros_arriba[i]: shadow nibbles i..N_DIGITOS-1 are all zero.
   always_comb begin
      ceros_arriba = '0;
      ceros_arriba[N_DIGITOS-1] = (sombra_dig[4*(N_DIGITOS-1) +: 4] == 4'h0);
      for (int i = N_DIGITOS - 2; i >= 0; i--) begin
         ceros_arriba[i] = ceros_arriba[i+1] && (sombra_dig[4*i +: 4] == 4'h0);
      end
   end

   assign nibble_sel = sombra_dig[4*int'(indice) +: 4];
   assign blanco     = sombra_msk[indice] || (sombra_sup && (indice != '0) && ceros_arriba[indice]);
   assign en_guarda  = (pre < PRE_GUARDA);

   decodificador_7seg u_decodificador (
      .nibble    (nibble_sel),
      .segmentos (seg_dec)
   );

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      an_act  = '0;
      seg_act = SEG_APAGADO;
      pt_act  = 1'b0;
      if (habilitar && !blanco) begin
         seg_act = seg_dec;
         pt_act  = sombra_pts[indice];
         if (!en_guarda) begin
            an_act[indice] = 1'b1;
         end
      end
   end

   // Output registers; pin polarity is applied only here.
   always_ff @(posedge reloj) begin
      if (reset) begin
         anodos    <= ANODOS_OFF;
         segmentos <= SEG_OFF;
         punto     <= PUNTO_OFF;
      end else begin
         anodos    <= ANODO_ACTIVO_BAJO ? ~an_act : an_act;
         segmentos <= SEG_ACTIVO_BAJO ? ~seg_act : seg_act;
         punto     <= SEG_ACTIVO_BAJO ? ~pt_act : pt_act;
      end
   end

endmodule

// File: tb/tb_barrido_displays_param.sv
// Scoreboard bench for barrido_displays_param (4 digits, 4-cycle slots, 1-cycle guard,
// active-low pins): stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_barrido_displays_param;

   typedef enum {C_AN, C_SEG, C_PT, C_IDX, C_TICK} campo_e;

   typedef struct {
      int          ciclo;
      campo_e      campo;
      logic [15:0] valor;
      string       nombre;
   } esperado_t;

   logic        reloj = 1'b0;
   logic        reset;
   logic        habilitar;
   logic [15:0] digitos;
   logic [3:0]  puntos;
   logic [3:0]  mascara;
   logic        supresion_ceros;
   logic [1:0]  indice;
   logic [3:0]  anodos;
   logic [6:0]  segmentos;
   logic        punto;
   logic        tick_cuadro;

   esperado_t cola[$];
   int ciclo  = 0;
   int base   = 0;
   int checks = 0;
   int errors = 0;

   barrido_displays_param #(
      .N_DIGITOS         (4),
      .DIV_REFRESCO      (4),
      .GUARDA            (1),
      .ANODO_ACTIVO_BAJO (1'b1),
      .SEG_ACTIVO_BAJO   (1'b1)
   ) dut (
      .reloj           (reloj),
      .reset           (reset),
      .habilitar       (habilitar),
      .digitos         (digitos),
      .puntos          (puntos),
      .mascara         (mascara),
      .supresion_ceros (supresion_ceros),
      .indice          (indice),
      .anodos          (anodos),
      .segmentos       (segmentos),
      .punto           (punto),
      .tick_cuadro     (tick_cuadro)
   );

   always #5 reloj = ~reloj;

   always @(posedge reloj) ciclo <= ciclo + 1;

   task automatic check(input string nombre, input logic [15:0] obtenido, input logic [15:0] esperado);
      checks++;
      if (obtenido !== esperado) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", nombre, obtenido, esperado, ciclo - base);
      end
   endtask

   function automatic logic [15:0] leer(input campo_e c);
      case (c)
         C_AN:    return {12'b0, anodos};
         C_SEG:   return {9'b0, segmentos};
         C_PT:    return {15'b0, punto};
         C_IDX:   return {14'b0, indice};
         default: return {15'b0, tick_cuadro};
      endcase
   endfunction

   // Expectation for the negedge that follows rising edge number base+d.
   task automatic esp(input int d, input campo_e c, input logic [15:0] v, input string nombre);
      cola.push_back('{base + d, c, v, nombre});
   endtask

   task automatic ir_a(input int n);
      while (ciclo < base + n) begin
         @(posedge reloj);
         #1;
      end
   endtask

   // Monitor: outputs are presented every cycle; compare whatever is due now.
   always @(negedge reloj) begin
      esperado_t e;
      while (cola.size() > 0 && cola[0].ciclo <= ciclo) begin
         e = cola.pop_front();
         if (e.ciclo < ciclo) check({e.nombre, "_missed"}, 16'(ciclo), 16'(e.ciclo));
         else                 check(e.nombre, leer(e.campo), e.valor);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1; habilitar = 1'b1; digitos = 16'h0008;
      puntos = 4'b0000; mascara = 4'b0000; supresion_ceros = 1'b0;
      repeat (3) @(posedge reloj);
      #1;
      reset = 1'b0;
      base  = ciclo;

      // Reset release, first frame, guard cycle, index walk and frame tick.
      esp(0,  C_AN, 'hF, "rst_an");    esp(0,  C_SEG, 'h7F, "rst_seg"); esp(0, C_PT, 'h1, "rst_pt");
      esp(0,  C_IDX, 'h0, "rst_idx");  esp(0,  C_TICK, 'h0, "rst_tick");
      esp(1,  C_AN, 'hF, "guard0_an"); esp(1,  C_SEG, 'h40, "old_shadow_seg"); esp(1, C_IDX, 'h0, "idx0");
      esp(2,  C_AN, 'hE, "d0_an");     esp(2,  C_SEG, 'h00, "d0_seg8");  esp(2, C_PT, 'h1, "d0_pt");
      esp(4,  C_IDX, 'h1, "idx1");     esp(4,  C_AN, 'hE, "d0_last_an");
      esp(5,  C_AN, 'hF, "guard1_an"); esp(5,  C_IDX, 'h1, "idx1_hold");
      esp(6,  C_AN, 'hD, "d1_an");     esp(6,  C_SEG, 'h40, "d1_seg0");
      esp(8,  C_IDX, 'h2, "idx2");     esp(12, C_IDX, 'h3, "idx3");
      esp(14, C_AN, 'h7, "d3_an");     esp(15, C_TICK, 'h0, "tick_early");
      esp(16, C_IDX, 'h0, "idx_wrap"); esp(16, C_TICK, 'h1, "tick_pulse");
      esp(17, C_TICK, 'h0, "tick_once"); esp(17, C_AN, 'hF, "guard_f2");
      esp(18, C_AN, 'hE, "f2_d0_an");  esp(18, C_SEG, 'h00, "f2_d0_seg");

      // Leading-zero suppression on 0105, then on 0000.
      ir_a(20);
      supresion_ceros = 1'b1; digitos = 16'h0105;
      esp(35, C_AN, 'hE, "lz_d0_an");  esp(35, C_SEG, 'h12, "lz_d0_seg5");
      esp(39, C_AN, 'hD, "lz_d1_an");  esp(39, C_SEG, 'h40, "lz_d1_seg0");
      esp(43, C_AN, 'hB, "lz_d2_an");  esp(43, C_SEG, 'h79, "lz_d2_seg1");
      esp(47, C_AN, 'hF, "lz_d3_dark"); esp(47, C_SEG, 'h7F, "lz_d3_seg"); esp(47, C_PT, 'h1, "lz_d3_pt");
      esp(48, C_AN, 'hF, "lz_d3_dark2");
      ir_a(36);
      digitos = 16'h0000;
      esp(51, C_AN, 'hE, "z_d0_an");   esp(51, C_SEG, 'h40, "z_d0_seg0");
      esp(55, C_AN, 'hF, "z_d1_dark"); esp(55, C_SEG, 'h7F, "z_d1_seg");
      esp(59, C_AN, 'hF, "z_d2_dark"); esp(63, C_AN, 'hF, "z_d3_dark");

      // Frame coherence: 1234 replaced by ABCD in the middle of slot 2.
      ir_a(52);
      supresion_ceros = 1'b0; digitos = 16'h1234;
      esp(67, C_AN, 'hE, "fc_d0_an");  esp(67, C_SEG, 'h19, "fc_d0_seg4");
      esp(71, C_AN, 'hD, "fc_d1_an");  esp(71, C_SEG, 'h30, "fc_d1_seg3");
      esp(73, C_IDX, 'h2, "fc_idx2");
      esp(75, C_AN, 'hB, "fc_d2_an");  esp(75, C_SEG, 'h24, "fc_d2_seg2");
      esp(79, C_AN, 'h7, "fc_d3_an");  esp(79, C_SEG, 'h79, "fc_d3_seg1");
      ir_a(73);
      digitos = 16'hABCD;
      esp(83, C_AN, 'hE, "nf_d0_an");  esp(83, C_SEG, 'h21, "nf_d0_segD");
      esp(87, C_AN, 'hD, "nf_d1_an");  esp(87, C_SEG, 'h46, "nf_d1_segC");

      // Per-digit mask and decimal point.
      ir_a(84);
      mascara = 4'b0100; puntos = 4'b0001;
      esp(99,  C_AN, 'hE, "mk_d0_an");  esp(99,  C_SEG, 'h21, "mk_d0_seg"); esp(99, C_PT, 'h0, "mk_d0_pt");
      esp(103, C_AN, 'hD, "mk_d1_an");  esp(103, C_PT, 'h1, "mk_d1_pt");
      esp(107, C_AN, 'hF, "mk_d2_dark"); esp(107, C_SEG, 'h7F, "mk_d2_seg"); esp(107, C_PT, 'h1, "mk_d2_pt");
      esp(111, C_AN, 'h7, "mk_d3_an");  esp(111, C_SEG, 'h08, "mk_d3_segA");

      // Enable dropped at indice=1, pre=2 for ten edges.
      ir_a(118);
      habilitar = 1'b0;
      esp(119, C_AN, 'hF, "off_an");   esp(119, C_SEG, 'h7F, "off_seg"); esp(119, C_PT, 'h1, "off_pt");
      esp(119, C_IDX, 'h1, "off_idx"); esp(124, C_IDX, 'h1, "off_idx_hold"); esp(124, C_AN, 'hF, "off_an_hold");
      esp(128, C_AN, 'hF, "off_an_end"); esp(128, C_IDX, 'h1, "off_idx_end"); esp(128, C_TICK, 'h0, "off_tick");
      esp(129, C_AN, 'hD, "resume_an"); esp(129, C_SEG, 'h46, "resume_seg"); esp(129, C_IDX, 'h1, "resume_idx");
      esp(130, C_IDX, 'h2, "resume_idx2");
      ir_a(128);
      habilitar = 1'b1;

      // Reset on the edge that would otherwise wrap the frame.
      ir_a(137);
      reset = 1'b1;
      esp(137, C_IDX, 'h3, "pre_rst_idx");
      esp(138, C_AN, 'hF, "mid_rst_an"); esp(138, C_SEG, 'h7F, "mid_rst_seg"); esp(138, C_PT, 'h1, "mid_rst_pt");
      esp(138, C_IDX, 'h0, "mid_rst_idx"); esp(138, C_TICK, 'h0, "mid_rst_tick");
      ir_a(138);
      reset = 1'b0;
      esp(139, C_TICK, 'h0, "post_rst_tick"); esp(139, C_IDX, 'h0, "post_rst_idx");
      esp(139, C_AN, 'hF, "post_rst_guard"); esp(139, C_SEG, 'h40, "post_rst_shadow");

      ir_a(142);
      @(negedge reloj);
      #1;
      while (cola.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got=unchecked expected=checked", cola[0].nombre);
         void'(cola.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
